// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the core data path.
//   Stores to TXDATA queue bytes in a small FIFO. An FSM shifts each byte out
//   LSB first, one bit every BAUDDIV clock cycles.
//   Ports:
//     clk, rst_n   core clock, synchronous active-low reset
//     addr, wdata  core data address and store data
//     mem_we       store strobe
//     sel          combinational window hit
//     rdata        combinational read data (0 when sel=0)
//     tx           serial line, idles high
//     busy         registered, FSM not idle
//     irq          registered, FIFO empty and FSM idle
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_we,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy,
    output logic        irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e        state_q;
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q;
    logic [15:0]   baud_q;
    logic [15:0]   div_q, cyc_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q, busy_q, irq_q;

    logic [1:0]    off;
    logic          wr, push_req, push_ok, pop;
    logic          fifo_empty, fifo_full, bit_end, going_idle;
    logic [6:0]    cnt_ext;
    logic [3:0]    cnt_sat;
    logic [7:0]    head;

    logic unused;
    assign unused = ^{addr[1:0], wdata[31:16]};

    assign sel        = (addr[31:4] == BASE_ADDR[31:4]);
    assign off        = addr[3:2];
    assign wr         = sel && mem_we;
    assign push_req   = wr && (off == 2'd0);
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
    assign head       = fifo_q[rptr_q];

    // Last cycle of the current bit period (start, data or stop bit).
    assign bit_end = (cyc_q == div_q - 16'd1);

    // Pop either from idle or straight out of the stop bit, so consecutive
    // frames have no idle gap between them.
    assign pop = !fifo_empty &&
                 ((state_q == IDLE) || ((state_q == STOP) && bit_end));

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push_req && (!fifo_full || pop);

    // FSM will be IDLE after this edge.
    assign going_idle = !pop && ((state_q == IDLE) ||
                                 ((state_q == STOP) && bit_end));

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop)
            cnt_d = cnt_q + CW'(1);
        else if (!push_ok && pop)
            cnt_d = cnt_q - CW'(1);
    end

    assign cnt_ext = 7'(cnt_q);
    assign cnt_sat = (cnt_ext > 7'd15) ? 4'hF : cnt_ext[3:0];

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (off)
                2'd1:    rdata = {20'd0, cnt_sat, 4'd0, ovf_q, busy_q,
                                  fifo_empty, fifo_full};
                2'd2:    rdata = {16'd0, baud_q};
                default: rdata = '0;
            endcase
        end
    end

    // FIFO storage needs no reset; emptiness is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_q[wptr_q] <= wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            baud_q <= DEFAULT_DIV;
        end else begin
            if (push_ok)
                wptr_q <= wptr_q + PW'(1);
            if (pop)
                rptr_q <= rptr_q + PW'(1);
            cnt_q <= cnt_d;
            if (push_req && !push_ok)
                ovf_q <= 1'b1;
            else if (wr && (off == 2'd1) && wdata[3])
                ovf_q <= 1'b0;
            if (wr && (off == 2'd2))
                baud_q <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            irq_q   <= 1'b1;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            div_q   <= DEFAULT_DIV;
        end else begin
            busy_q <= !going_idle;
            irq_q  <= going_idle && (cnt_d == '0);
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= head;
                        div_q   <= baud_q;
                        cyc_q   <= '0;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cyc_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        cyc_q <= cyc_q + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cyc_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        cyc_q <= cyc_q + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cyc_q <= '0;
                        if (pop) begin
                            shift_q <= head;
                            div_q   <= baud_q;
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        cyc_q <= cyc_q + 16'd1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign irq  = irq_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed and randomized checks of mmio_uart_tx against a
//   frame-level reference model (byte queue plus frame start time and period).
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_we = 1'b0;
    logic        sel, tx, busy, irq;
    logic [31:0] rdata;

    mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd868)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .mem_we(mem_we),
        .sel(sel), .rdata(rdata), .tx(tx), .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int busy_cycles = 0;

    // Reference model: queued bytes, sticky overflow, baud register, and the
    // frame in flight described by start edge, period and byte.
    int   e = 0;
    int   q[$];
    bit   act = 0;
    bit   ovf = 0;
    int   baud = 868;
    int   fs = 0, fd = 1, fb = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, e);
        end
    endtask

    function automatic logic exp_tx();
        int k;
        if (!act) return 1'b1;
        k = (e - fs) / fd;
        if (k == 0) return 1'b0;
        if (k <= 8) return 1'((fb >> (k - 1)) & 1);
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        int n;
        if (a[31:4] != BASE[31:4]) return 32'd0;
        n = q.size();
        case (a[3:2])
            2'd1: return {20'd0, 4'((n > 15) ? 15 : n), 4'd0, ovf, act,
                          (n == 0), (n == DEPTH)};
            2'd2: return 32'(baud);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit w, input logic [1:0] o,
                              input logic [31:0] d);
        if (!r) begin
            q.delete();
            act = 0;
            ovf = 0;
            baud = 868;
        end else begin
            if (act && e == fs + 10 * fd) act = 0;
            if (!act && q.size() > 0) begin
                fb = q.pop_front();
                fs = e;
                fd = baud;
                act = 1;
            end
            if (w) begin
                case (o)
                    2'd0: if (q.size() < DEPTH) q.push_back(int'(d[7:0])); else ovf = 1;
                    2'd1: if (d[3]) ovf = 0;
                    2'd2: baud = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
                    default: ;
                endcase
            end
        end
    endtask

    // One clock edge: model the edge with the inputs presented before it,
    // then compare the registered outputs just after it.
    task automatic cycle();
        bit r = rst_n;
        bit w = mem_we && (addr[31:4] == BASE[31:4]);
        logic [1:0] o = addr[3:2];
        logic [31:0] d = wdata;
        @(posedge clk);
        e++;
        model_step(r, w, o, d);
        #1;
        chk("tx", 32'(tx), 32'(exp_tx()));
        chk("busy", 32'(busy), 32'(act));
        chk("irq", 32'(irq), 32'(!act && q.size() == 0));
        if (busy) busy_cycles++;
    endtask

    task automatic do_write(input int off, input logic [31:0] d);
        addr = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
        wdata = d;
        mem_we = 1'b1;
        cycle();
        mem_we = 1'b0;
    endtask

    task automatic idle(input int n);
        mem_we = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic rd(input string tag, input int off, input logic [31:0] exp);
        mem_we = 1'b0;
        addr = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
        #1;
        chk(tag, rdata, exp);
        chk({tag, "_model"}, rdata, exp_rdata(addr));
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        rd("rst_status", 1, 32'h0000_0002);
        rd("rst_baud", 2, 32'd868);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_irq", 32'(irq), 32'd1);

        // Single frame 0xA5 at 4 cycles per bit
        do_write(2, 32'd4);
        busy_cycles = 0;
        do_write(0, 32'hA5);
        idle(50);
        chk("a5_busy_len", 32'(busy_cycles), 32'd40);

        // Ten back-to-back bytes: nine accepted, overflow on the tenth
        busy_cycles = 0;
        for (int i = 0; i < 10; i++) do_write(0, 32'(i));
        rd("ovf_status", 1, 32'h0000_080D);
        do_write(1, 32'h8);
        rd("ovf_clear", 1, 32'h0000_0805);
        idle(400);
        chk("burst_busy_len", 32'(busy_cycles), 32'd360);

        // Baud change mid-frame applies to the next frame only
        busy_cycles = 0;
        do_write(0, 32'h3C);
        do_write(0, 32'hC3);
        idle(15);
        do_write(2, 32'd2);
        idle(100);
        chk("midbaud_busy_len", 32'(busy_cycles), 32'd60);

        // Reset during bit 3 with three bytes queued
        do_write(2, 32'd4);
        for (int i = 0; i < 4; i++) do_write(0, 32'h50 + 32'(i));
        idle(14);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("midrst_tx", 32'(tx), 32'd1);
        rd("midrst_status", 1, 32'h0000_0002);
        busy_cycles = 0;
        idle(100);
        chk("midrst_quiet", 32'(busy_cycles), 32'd0);
        do_write(2, 32'd0);
        rd("baud_zero", 2, 32'd1);

        // Randomized traffic with small bit periods
        do_write(2, 32'd2);
        for (int i = 0; i < 3000; i++) begin
            int r = int'($urandom_range(0, 99));
            if (r < 2) begin
                rst_n = 1'b0;
                cycle();
                rst_n = 1'b1;
                do_write(2, 32'($urandom_range(0, 3)));
            end else if (r < 20) begin
                do_write(0, $urandom);
            end else if (r < 25) begin
                do_write(2, {$urandom_range(0, 1) == 0 ? 16'hFFFF : 16'h0,
                             16'($urandom_range(0, 3))});
            end else if (r < 30) begin
                do_write(1, $urandom);
            end else if (r < 34) begin
                addr = BASE + 32'h10 + 32'($urandom_range(0, 15));
                wdata = $urandom;
                mem_we = 1'b1;
                cycle();
                mem_we = 1'b0;
            end else begin
                mem_we = 1'b0;
                addr = (r < 40) ? $urandom : BASE + 32'($urandom_range(0, 15));
                #1;
                chk("rand_rdata", rdata, exp_rdata(addr));
                chk("rand_sel", 32'(sel), 32'(addr[31:4] == BASE[31:4]));
                cycle();
            end
        end
        idle(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the single-cycle core's data-memory path, in parallel with DMEM.
- Decodes core load/store accesses in its address window and queues store bytes in an internal FIFO.
- Serialises bytes as 8N1 frames on tx, LSB first, with a programmable bit period.
- Supplies combinational read data and a hit flag so the top level can mux it against DMEM read data in the same cycle.

Parameters:
- BASE_ADDR, 32'h0000_1000, base of the 16-byte register window; must be 16-byte aligned.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, range 2..64.
- DEFAULT_DIV, 16'd868, reset value of the bit period in clk cycles (100 MHz / 115200).

Ports:
- clk  input  1  rising-edge clock, the core clock.
- rst_n  input  1  reset, synchronous, active-low.
- addr  input  32  core data address (ALU result).
- wdata  input  32  core store data (rs2).
- mem_we  input  1  store strobe (core MemRW).
- sel  output  1  combinational: addr[31:4] == BASE_ADDR[31:4].
- rdata  output  32  combinational read data; 0 when sel=0.
- tx  output  1  serial line; idles high.
- busy  output  1  registered: 1 when the FSM is not IDLE.
- irq  output  1  registered: 1 when the FIFO is empty and the FSM is IDLE.

Behaviour:
- Register map (offset = addr[3:2]):
  - 0 TXDATA: write-only; a write pushes wdata[7:0]; reads return 0.
  - 1 STATUS: bit0 fifo_full, bit1 fifo_empty, bit2 busy, bit3 overflow (sticky), bits[11:8] fifo count (saturates at 15); all other bits read 0.
    - Writing with wdata[3]=1 clears overflow; other bits are ignored.
  - 2 BAUDDIV: read/write; bits[15:0] hold the bit period in cycles; a written value of 0 is stored as 1.
  - 3: reads 0; writes are ignored.
- A write takes effect only when sel && mem_we, at the rising edge; addr[1:0] is ignored.
- Synchronous reset (rst_n=0 at an edge):
  - FSM to IDLE, tx=1, busy=0, irq=1.
  - FIFO emptied, overflow=0, BAUDDIV=DEFAULT_DIV.
  - Applies mid-frame: the frame is aborted, tx is high after that edge, and queued bytes are discarded.
- FIFO push and pop:
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set at that edge.
  - The count never exceeds FIFO_DEPTH.
- FSM states IDLE, START, DATA, STOP; bit counter bit_cnt[2:0]; cycle counter cyc_cnt[15:0].
  - The bit period DIV is latched from BAUDDIV when entering START. A BAUDDIV write mid-frame affects the next frame only.
  - IDLE: tx=1. If the FIFO is non-empty at an edge, pop the head into the shift register, go to START, cyc_cnt=0.
    - A byte written at edge N into an idle, empty block is popped at edge N+1.
    - tx falls after edge N+1.
  - START: tx=0 for DIV cycles, then DATA with bit_cnt=0.
  - DATA: tx=shift[0] for DIV cycles per bit, shifting right at each bit boundary; after bit 7 go to STOP.
  - STOP: tx=1 for DIV cycles. At the end of STOP:
    - FIFO non-empty: pop and go directly to START. There is no extra idle cycle between frames.
    - FIFO empty: go to IDLE.
- Frame length is exactly 10*DIV cycles.
- Capacity: with back-to-back writes into an idle block, FIFO_DEPTH+1 bytes are accepted (one in the shift register, FIFO_DEPTH queued).
- rdata and sel are purely combinational from addr and current register state; there is no read side effect.
- busy and irq are registered; a pushed byte makes irq go low at the same edge as the push.

Test Plan:
- Reset, then read STATUS and BAUDDIV -> STATUS=32'h0000_0002, BAUDDIV=868, tx=1, irq=1.
- BAUDDIV=4, then write TXDATA=0xA5 -> tx low 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then high 4 cycles; busy high for exactly 40 cycles.
- BAUDDIV=4, write 10 bytes 0x00..0x09 on consecutive cycles -> overflow=1 after the 10th write, 0x00..0x08 transmitted back-to-back (360 cycles, no gaps), 0x09 never sent.
- Write STATUS with wdata=32'h8 after an overflow -> overflow reads 0; FIFO contents unaffected.
- Mid-frame BAUDDIV write 4->2 during DATA -> current frame keeps 4-cycle bits; next frame uses 2-cycle bits (20 cycles).
- rst_n=0 for one edge during bit 3 of a frame with 3 bytes queued -> tx=1, busy=0, count=0 after that edge; nothing further transmitted. Write BAUDDIV=0 -> reads 1.
